// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int IW = 9;

    localparam logic [IW-1:0] NOP_INSTR = 9'b0;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: start, halt, redirect, stall, increment.
import fetch_pkg::*;

module fetch_unit_next_pc #(
    parameter int D = 10
) (
    input  fetch_state_t state,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    input  logic         halt,
    input  logic         redirect_valid,
    input  logic         redirect_rel,
    input  logic [D-1:0] redirect_target,
    input  logic         stall,
    input  logic [D-1:0] prog_ctr,
    input  logic [D-1:0] instr_pc,
    output logic [D-1:0] pc_next,
    output logic         flush,
    output logic         fetch
);

    logic [D-1:0] target;

    // D-bit add wraps modulo 2**D, which is exactly the sign-extended sum.
    always_comb begin
        target = redirect_target;
        if (redirect_rel) begin
            target = instr_pc + redirect_target;
        end
    end

    always_comb begin
        pc_next = prog_ctr;
        flush   = 1'b0;
        fetch   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    pc_next = start_addr;
                end
            end
            RUN: begin
                if (halt) begin
                    pc_next = prog_ctr;
                end else if (redirect_valid) begin
                    pc_next = target;
                    flush   = 1'b1;
                end else if (!stall) begin
                    pc_next = prog_ctr + 1'b1;
                    fetch   = 1'b1;
                end
            end
            default: begin
                pc_next = prog_ctr;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures ROM data into the fetch register.
import fetch_pkg::*;

module fetch_unit #(
    parameter int D  = 10,
    parameter int IW = fetch_pkg::IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic          redirect_rel,
    input  logic [D-1:0]  redirect_target,
    input  logic          halt,
    output logic [D-1:0]  prog_ctr,
    input  logic [IW-1:0] mach_code,
    output logic [IW-1:0] instr_out,
    output logic [D-1:0]  instr_pc,
    output logic          instr_valid,
    output logic          running,
    output logic          done
);

    fetch_state_t state;
    logic [D-1:0] pc_next;
    logic         flush;
    logic         fetch;

    fetch_unit_next_pc #(
        .D(D)
    ) u_next_pc (
        .state           (state),
        .start           (start),
        .start_addr      (start_addr),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_rel    (redirect_rel),
        .redirect_target (redirect_target),
        .stall           (stall),
        .prog_ctr        (prog_ctr),
        .instr_pc        (instr_pc),
        .pc_next         (pc_next),
        .flush           (flush),
        .fetch           (fetch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prog_ctr    <= '0;
            instr_out   <= IW'(NOP_INSTR);
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            prog_ctr <= pc_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state       <= DONE;
                        instr_valid <= 1'b0;
                        running     <= 1'b0;
                        done        <= 1'b1;
                    end else if (flush) begin
                        instr_valid <= 1'b0;
                    end else if (fetch) begin
                        instr_out   <= mach_code;
                        instr_pc    <= prog_ctr;
                        instr_valid <= 1'b1;
                    end
                end
                DONE: begin
                    instr_valid <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    running     <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural ROM.
module tb_fetch_unit;

    localparam int D  = 10;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [D-1:0]  start_addr;
    logic          stall;
    logic          redirect_valid;
    logic          redirect_rel;
    logic [D-1:0]  redirect_target;
    logic          halt;
    logic [D-1:0]  prog_ctr;
    logic [IW-1:0] mach_code;
    logic [IW-1:0] instr_out;
    logic [D-1:0]  instr_pc;
    logic          instr_valid;
    logic          running;
    logic          done;

    logic [IW-1:0] rom [0:(1<<D)-1];

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign mach_code = rom[prog_ctr];

    fetch_unit #(.D(D), .IW(IW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_addr      (start_addr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_rel    (redirect_rel),
        .redirect_target (redirect_target),
        .halt            (halt),
        .prog_ctr        (prog_ctr),
        .mach_code       (mach_code),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .running         (running),
        .done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << D); i++) begin
            rom[i] = IW'((i * 37 + 5) % 512);
        end
        rom[0] = 9'h0A1;
        rom[1] = 9'h0B2;
        rom[2] = 9'h0C3;

        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_rel = 1'b0;
        redirect_target = '0;
        halt = 1'b0;

        #12;
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_instr", 32'(instr_out), 0);
        chk("rst_ipc", 32'(instr_pc), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;

        step();
        chk("idle_hold_pc", 32'(prog_ctr), 0);
        chk("idle_running", 32'(running), 0);

        start = 1'b1;
        start_addr = 10'd0;
        step();
        start = 1'b0;
        chk("start_pc", 32'(prog_ctr), 0);
        chk("start_valid", 32'(instr_valid), 0);
        chk("start_running", 32'(running), 1);

        step();
        chk("f0_instr", 32'(instr_out), 32'h0A1);
        chk("f0_ipc", 32'(instr_pc), 0);
        chk("f0_valid", 32'(instr_valid), 1);
        chk("f0_pc", 32'(prog_ctr), 1);
        step();
        chk("f1_instr", 32'(instr_out), 32'h0B2);
        chk("f1_ipc", 32'(instr_pc), 1);
        chk("f1_pc", 32'(prog_ctr), 2);
        step();
        chk("f2_instr", 32'(instr_out), 32'h0C3);
        chk("f2_ipc", 32'(instr_pc), 2);
        chk("f2_pc", 32'(prog_ctr), 3);

        step();
        step();
        step();
        chk("pre_stall_ipc", 32'(instr_pc), 5);
        chk("pre_stall_pc", 32'(prog_ctr), 6);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", 32'(prog_ctr), 6);
            chk("stall_ipc", 32'(instr_pc), 5);
            chk("stall_instr", 32'(instr_out), 32'(rom[5]));
            chk("stall_valid", 32'(instr_valid), 1);
        end
        stall = 1'b0;
        step();
        chk("resume_ipc", 32'(instr_pc), 6);
        chk("resume_instr", 32'(instr_out), 32'(rom[6]));
        chk("resume_pc", 32'(prog_ctr), 7);

        for (int k = 0; k < 14; k++) begin
            step();
        end
        chk("pre_rel_ipc", 32'(instr_pc), 20);
        chk("pre_rel_pc", 32'(prog_ctr), 21);

        redirect_valid = 1'b1;
        redirect_rel = 1'b1;
        redirect_target = 10'h3FC;
        step();
        redirect_valid = 1'b0;
        chk("rel_pc", 32'(prog_ctr), 16);
        chk("rel_bubble", 32'(instr_valid), 0);
        chk("rel_ipc_hold", 32'(instr_pc), 20);
        step();
        chk("rel_fetch_ipc", 32'(instr_pc), 16);
        chk("rel_fetch_instr", 32'(instr_out), 32'(rom[16]));
        chk("rel_fetch_valid", 32'(instr_valid), 1);
        chk("rel_fetch_pc", 32'(prog_ctr), 17);

        redirect_valid = 1'b1;
        redirect_rel = 1'b0;
        redirect_target = 10'd1023;
        stall = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        chk("abs_pc", 32'(prog_ctr), 1023);
        chk("abs_bubble", 32'(instr_valid), 0);
        chk("abs_ipc_hold", 32'(instr_pc), 16);
        step();
        chk("abs_fetch_ipc", 32'(instr_pc), 1023);
        chk("abs_fetch_instr", 32'(instr_out), 32'(rom[1023]));
        chk("wrap_pc", 32'(prog_ctr), 0);
        step();
        chk("wrap_ipc", 32'(instr_pc), 0);
        chk("wrap_next_pc", 32'(prog_ctr), 1);

        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 10'd500;
        step();
        halt = 1'b0;
        redirect_valid = 1'b0;
        chk("halt_done", 32'(done), 1);
        chk("halt_running", 32'(running), 0);
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_pc", 32'(prog_ctr), 1);

        redirect_valid = 1'b1;
        redirect_target = 10'd300;
        step();
        redirect_valid = 1'b0;
        chk("done_redir_pc", 32'(prog_ctr), 1);
        chk("done_hold", 32'(done), 1);

        start = 1'b1;
        start_addr = 10'd100;
        step();
        start = 1'b0;
        chk("restart_running", 32'(running), 1);
        chk("restart_done", 32'(done), 0);
        chk("restart_pc", 32'(prog_ctr), 100);
        chk("restart_valid", 32'(instr_valid), 0);
        step();
        chk("restart_ipc", 32'(instr_pc), 100);
        chk("restart_instr", 32'(instr_out), 32'(rom[100]));
        chk("restart_vld", 32'(instr_valid), 1);

        start = 1'b1;
        start_addr = 10'd7;
        step();
        start = 1'b0;
        chk("run_start_pc", 32'(prog_ctr), 102);
        chk("run_start_ipc", 32'(instr_pc), 101);

        #2;
        reset = 1'b1;
        #1;
        chk("async_pc", 32'(prog_ctr), 0);
        chk("async_valid", 32'(instr_valid), 0);
        chk("async_running", 32'(running), 0);
        chk("async_done", 32'(done), 0);
        chk("async_ipc", 32'(instr_pc), 0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("post_rst_pc", 32'(prog_ctr), 0);
        chk("post_rst_valid", 32'(instr_valid), 0);
        chk("post_rst_running", 32'(running), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
